// File: rtl/audio_frame_buffer_pkg.sv
// Shared types for the audio frame buffer.
//   SAMPLE_W : width of one codec sample
//   FRAME_W  : width of one stereo frame
//   frame_t  : {left, right} stereo frame, left in the upper half
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = 32;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } frame_t;

endpackage

// File: rtl/audio_frame_buffer_if.sv
// Host-side streams of the audio frame buffer.
//   play_data/play_valid/play_ready : playback frames, host -> buffer
//   rec_data/rec_valid/rec_ready    : recorded frames, buffer -> host
// master modport is the host, slave modport is the buffer.
interface audio_frame_buffer_if;
  import audio_pkg::*;

  frame_t play_data;
  logic   play_valid;
  logic   play_ready;
  frame_t rec_data;
  logic   rec_valid;
  logic   rec_ready;

  modport master (
    output play_data, play_valid, rec_ready,
    input  play_ready, rec_data, rec_valid
  );

  modport slave (
    input  play_data, play_valid, rec_ready,
    output play_ready, rec_data, rec_valid
  );

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead frame FIFO, 2^DEPTH_LOG2 entries.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write a frame (ignored when full)
//   pop        : drop the head frame (ignored when empty)
//   rdata      : head frame, read from registered storage
//   full/empty : derived from the registered level only
//   level      : occupancy, 0..2^DEPTH_LOG2
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  frame_t              wdata,
  input  logic                pop,
  output frame_t              rdata,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  frame_t                mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_ok, pop_ok;

  // Level can never exceed Depth, so its MSB alone marks full.
  assign full    = level_q[DEPTH_LOG2];
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  // No bypass: a pop only succeeds on frames already stored.
  assign pop_ok  = pop && !empty;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + (DEPTH_LOG2 + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset; pointer reset discards its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Stereo frame buffer between host streams and the codec serializer.
//   clk, reset   : clock, synchronous active-high reset
//   run          : enables codec-side pops/pushes; low forces audio_output to 0
//   sample_req   : [1] left / [0] right playback request pulses
//   sample_end   : [1] left / [0] right capture-complete pulses
//   audio_input  : captured sample, valid with sample_end
//   audio_output : registered playback sample
//   bus          : playback and record valid/ready streams
//   play_level, rec_level : FIFO occupancies
//   underrun_cnt, overrun_cnt : saturating event counters, present only when
//                  AUDIO_FRAME_BUFFER_XRUN_CNT_EN is defined
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            sample_req,
  input  logic [1:0]            sample_end,
  input  logic [SAMPLE_W-1:0]   audio_input,
  output logic [SAMPLE_W-1:0]   audio_output,
  audio_frame_buffer_if.slave   bus,
  output logic [DEPTH_LOG2:0]   play_level,
  output logic [DEPTH_LOG2:0]   rec_level
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt,
  output logic [15:0]           overrun_cnt
`endif
);

  logic [SAMPLE_W-1:0] audio_output_q, right_hold_q, left_hold_q;
  frame_t              play_head, rec_frame;
  logic                play_full, play_empty, play_push, play_pop_req, play_pop;
  logic                rec_full, rec_empty, rec_push_req, rec_push, rec_pop;

  assign bus.play_ready = !play_full;
  assign play_push      = bus.play_valid && !play_full;
  assign play_pop_req   = sample_req[1] && run;
  assign play_pop       = play_pop_req && !play_empty;

  assign rec_frame      = '{left: left_hold_q, right: audio_input};
  assign rec_push_req   = sample_end[0] && run;
  assign rec_push       = rec_push_req && !rec_full;
  assign bus.rec_valid  = !rec_empty;
  assign rec_pop        = !rec_empty && bus.rec_ready;

  assign audio_output   = audio_output_q;

  audio_frame_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_play_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (play_push),
    .wdata (bus.play_data),
    .pop   (play_pop),
    .rdata (play_head),
    .full  (play_full),
    .empty (play_empty),
    .level (play_level)
  );

  audio_frame_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rec_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rec_push),
    .wdata (rec_frame),
    .pop   (rec_pop),
    .rdata (bus.rec_data),
    .full  (rec_full),
    .empty (rec_empty),
    .level (rec_level)
  );

  // Left request has priority should both request bits ever coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_output_q <= '0;
      right_hold_q   <= '0;
      left_hold_q    <= '0;
    end else begin
      if (!run) begin
        audio_output_q <= '0;
      end else if (sample_req[1]) begin
        // An empty FIFO plays silence on both channels.
        audio_output_q <= play_empty ? '0 : play_head.left;
        right_hold_q   <= play_empty ? '0 : play_head.right;
      end else if (sample_req[0]) begin
        audio_output_q <= right_hold_q;
      end
      if (sample_end[1] && run) left_hold_q <= audio_input;
    end
  end

`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
  logic        underrun, overrun;
  logic [15:0] underrun_cnt_q, overrun_cnt_q;

  assign underrun     = play_pop_req && play_empty;
  assign overrun      = rec_push_req && rec_full;
  assign underrun_cnt = underrun_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt_q <= '0;
      overrun_cnt_q  <= '0;
    end else begin
      if (underrun && underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
      if (overrun && overrun_cnt_q != 16'hFFFF)   overrun_cnt_q  <= overrun_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Scoreboard bench for audio_frame_buffer (DEPTH_LOG2 = 4).
module tb_audio_frame_buffer;
  import audio_pkg::*;

  localparam int unsigned DL = 4;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [1:0]  sample_req, sample_end;
  logic [15:0] audio_input, audio_output;
  logic [DL:0] play_level, rec_level;
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
  logic [15:0] underrun_cnt, overrun_cnt;
`endif

  audio_frame_buffer_if bus_if ();

  audio_frame_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .sample_req   (sample_req),
    .sample_end   (sample_end),
    .audio_input  (audio_input),
    .audio_output (audio_output),
    .bus          (bus_if),
    .play_level   (play_level),
    .rec_level    (rec_level)
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_audio[$];
  logic [31:0] exp_rec[$];
  logic        aud_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: inputs are stable at the falling edge and are what the next rising edge samples.
  always @(negedge clk) begin
    if (aud_pend) begin
      if (exp_audio.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL audio_output: got %h with no expected sample queued", audio_output);
      end else begin
        chk("audio_output", {16'h0, audio_output}, {16'h0, exp_audio.pop_front()});
      end
    end
    aud_pend = (sample_req != 2'b00) && !reset;
    if (bus_if.rec_valid && bus_if.rec_ready && !reset) begin
      if (exp_rec.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rec_data: got %h with no expected frame queued", bus_if.rec_data);
      end else begin
        chk("rec_data", bus_if.rec_data, exp_rec.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] r, input logic [15:0] exp);
    sample_req = r;
    exp_audio.push_back(exp);
    cycle();
    sample_req = 2'b00;
  endtask

  task automatic rec_frame(input logic [15:0] l, input logic [15:0] r);
    sample_end  = 2'b10;
    audio_input = l;
    cycle();
    sample_end  = 2'b01;
    audio_input = r;
    cycle();
    sample_end  = 2'b00;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; sample_req = '0; sample_end = '0; audio_input = '0;
    bus_if.play_data = '0; bus_if.play_valid = 1'b0; bus_if.rec_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    chk("reset play_level", 32'(play_level), 32'd0);
    chk("reset rec_level", 32'(rec_level), 32'd0);
    chk("reset play_ready", 32'(bus_if.play_ready), 32'd1);
    chk("reset rec_valid", 32'(bus_if.rec_valid), 32'd0);
    chk("reset audio_output", 32'(audio_output), 32'd0);

    // Playback pass-through
    bus_if.play_valid = 1'b1; bus_if.play_data = 32'h1111_2222; cycle();
    bus_if.play_data = 32'h3333_4444; cycle();
    bus_if.play_valid = 1'b0;
    chk("pass level2", 32'(play_level), 32'd2);
    req(2'b10, 16'h1111);
    chk("pass level1", 32'(play_level), 32'd1);
    req(2'b01, 16'h2222);
    req(2'b10, 16'h3333);
    chk("pass level0", 32'(play_level), 32'd0);
    req(2'b01, 16'h4444);

    // Playback underrun
    req(2'b10, 16'h0000);
    req(2'b01, 16'h0000);
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif

    // Record assembly
    rec_frame(16'hAAAA, 16'h5555);
    chk("rec valid", 32'(bus_if.rec_valid), 32'd1);
    chk("rec level1", 32'(rec_level), 32'd1);
    exp_rec.push_back(32'hAAAA_5555);
    bus_if.rec_ready = 1'b1; cycle(); bus_if.rec_ready = 1'b0;
    chk("rec level0", 32'(rec_level), 32'd0);
    chk("rec valid0", 32'(bus_if.rec_valid), 32'd0);

    // Record overrun: one frame more than the FIFO holds
    for (int i = 0; i <= 16; i++) begin
      rec_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      if (i < 16) exp_rec.push_back({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    end
    chk("ovr rec_level", 32'(rec_level), 32'd16);
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
    chk("overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif
    bus_if.rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    bus_if.rec_ready = 1'b0;
    chk("ovr drained level", 32'(rec_level), 32'd0);
    chk("ovr frames left", 32'(exp_rec.size()), 32'd0);

    // Playback full and concurrency
    bus_if.play_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.play_data = {16'h0A00 + 16'(i), 16'h0B00 + 16'(i)};
      cycle();
    end
    chk("full play_ready", 32'(bus_if.play_ready), 32'd0);
    chk("full level", 32'(play_level), 32'd16);
    bus_if.play_data = 32'hDEAD_BEEF;
    cycle();
    chk("full ignore valid", 32'(play_level), 32'd16);
    req(2'b10, 16'h0A00);
    chk("full pop level", 32'(play_level), 32'd15);
    chk("full pop ready", 32'(bus_if.play_ready), 32'd1);
    req(2'b10, 16'h0A01);
    chk("push+pop level", 32'(play_level), 32'd15);
    bus_if.play_valid = 1'b0;
    req(2'b01, 16'h0B01);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) rec_frame(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    chk("pre-reset rec_level", 32'(rec_level), 32'd3);
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("mid reset play_level", 32'(play_level), 32'd0);
    chk("mid reset rec_level", 32'(rec_level), 32'd0);
    chk("mid reset audio", 32'(audio_output), 32'd0);
    chk("mid reset play_ready", 32'(bus_if.play_ready), 32'd1);
    chk("mid reset rec_valid", 32'(bus_if.rec_valid), 32'd0);
`ifdef AUDIO_FRAME_BUFFER_XRUN_CNT_EN
    chk("mid reset underrun_cnt", 32'(underrun_cnt), 32'd0);
    chk("mid reset overrun_cnt", 32'(overrun_cnt), 32'd0);
`endif

    // Run control
    bus_if.play_valid = 1'b1; bus_if.play_data = 32'h7777_8888; cycle();
    bus_if.play_valid = 1'b0;
    run = 1'b0;
    req(2'b10, 16'h0000);
    chk("run0 no pop", 32'(play_level), 32'd1);
    req(2'b01, 16'h0000);
    rec_frame(16'h1234, 16'h5678);
    chk("run0 no rec push", 32'(rec_level), 32'd0);
    run = 1'b1;
    req(2'b10, 16'h7777);
    chk("run1 pop level", 32'(play_level), 32'd0);
    run = 1'b0;
    cycle();
    chk("run0 forces zero", 32'(audio_output), 32'd0);
    run = 1'b1;
    cycle(); cycle();
    chk("audio queue empty", 32'(exp_audio.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
